// File: rtl/tsa_pkg.sv
// Shared constants for the tilemap shifter array: per-channel mode encodings
// and the pixel-index width helper.
package tsa_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  function automatic int tsa_pw(input int npx);
    return $clog2(npx);
  endfunction

endpackage

// File: rtl/tsa_channel.sv
// One tilemap layer: row latch, bidirectional pixel shifter with remaining-count
// and sticky underrun, then fixed pipeline delay, fine-scroll delay and output register.
module tsa_channel
  import tsa_pkg::*;
#(
  parameter int PXW = 4,
  parameter int NPX = 8,
  parameter int PW = 3,
  parameter logic [PW-1:0] LATCH_PHASE = '0,
  parameter int ODLY = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cen_n,
  input  logic [PW-1:0]        hcnt,
  input  logic [NPX*PXW-1:0]   gfxdata,
  input  logic [1:0]           mode,
  input  logic                 flip,
  input  logic [PW-1:0]        fine,
  input  logic                 clr_underrun,
  output logic [PXW-1:0]       pixel,
  output logic                 trn_n,
  output logic                 underrun
);

  localparam int RW = NPX * PXW;
  localparam int RMW = PW + 1;
  localparam logic [PW:0] REM_FULL = RMW'(NPX);
  localparam logic [PW:0] REM_ONE = RMW'(1);

  logic [RW-1:0]  line_latch;
  logic [RW-1:0]  shift_reg;
  logic [PW:0]    rem;
  logic [PXW-1:0] stage;
  logic [PXW-1:0] dly_out;
  logic [PXW-1:0] tap;
  logic [PXW-1:0] fine_line [NPX];

  logic dir_ok;
  logic shifting;
  logic starve;

  // A shift only counts when its direction agrees with the flip setting.
  always_comb begin
    dir_ok   = ((mode == MODE_SHL) && !flip) || ((mode == MODE_SHR) && flip);
    shifting = dir_ok && (rem != '0);
    starve   = dir_ok && (rem == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      line_latch <= '0;
      shift_reg  <= '0;
      rem        <= '0;
      stage      <= '0;
      underrun   <= 1'b0;
    end else if (!cen_n) begin
      if (hcnt == LATCH_PHASE) begin
        line_latch <= gfxdata;
      end
      case (mode)
        MODE_LOAD: begin
          shift_reg <= line_latch;
          rem       <= REM_FULL;
        end
        MODE_SHL, MODE_SHR: begin
          if (shifting) begin
            rem <= rem - REM_ONE;
            // Pixel 0 sits in the MSBs, so "toward NPX-1" is a move toward the LSBs.
            if (flip) begin
              stage     <= shift_reg[PXW-1:0];
              shift_reg <= {{PXW{1'b0}}, shift_reg[RW-1:PXW]};
            end else begin
              stage     <= shift_reg[RW-1 -: PXW];
              shift_reg <= {shift_reg[RW-PXW-1:0], {PXW{1'b0}}};
            end
          end else begin
            stage <= '0;
          end
        end
        default: begin
        end
      endcase
      if (starve) begin
        underrun <= 1'b1;
      end else if (clr_underrun) begin
        underrun <= 1'b0;
      end
    end
  end

  generate
    if (ODLY == 0) begin : g_no_fixed
      assign dly_out = stage;
    end else begin : g_fixed
      logic [PXW-1:0] pipe [ODLY];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < ODLY; i++) begin
            pipe[i] <= '0;
          end
        end else if (!cen_n) begin
          pipe[0] <= stage;
          for (int i = 1; i < ODLY; i++) begin
            pipe[i] <= pipe[i-1];
          end
        end
      end

      assign dly_out = pipe[ODLY-1];
    end
  endgenerate

  // Fine scroll of zero bypasses the delay line entirely.
  always_comb begin
    tap = dly_out;
    if (fine != '0) begin
      tap = fine_line[fine - PW'(1)];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NPX; i++) begin
        fine_line[i] <= '0;
      end
      pixel <= '0;
    end else if (!cen_n) begin
      fine_line[0] <= dly_out;
      for (int i = 1; i < NPX; i++) begin
        fine_line[i] <= fine_line[i-1];
      end
      pixel <= tap;
    end
  end

  assign trn_n = |pixel;

endmodule

// File: rtl/tilemap_shifter_array.sv
// Multi-layer tilemap pixel serialiser: one tsa_channel per layer, fed by
// slices of the packed control vectors and per-layer parameters.
module tilemap_shifter_array
  import tsa_pkg::*;
#(
  parameter int NCH = 2,
  parameter int PXW = 4,
  parameter int NPX = 8,
  parameter logic [NCH*tsa_pw(NPX)-1:0] LATCH_PHASE = {3'd3, 3'd7},
  parameter logic [NCH*8-1:0] ODLY = {8'd0, 8'd3}
) (
  input  logic                          i_EMU_MCLK,
  input  logic                          i_EMU_RST,
  input  logic                          i_EMU_CLK6MPCEN_n,
  input  logic [tsa_pw(NPX)-1:0]        i_HCNT,
  input  logic [NPX*PXW-1:0]            i_GFXDATA,
  input  logic [NCH*2-1:0]              i_MODE,
  input  logic [NCH-1:0]                i_FLIP,
  input  logic [NCH*tsa_pw(NPX)-1:0]    i_FINE,
  input  logic [NCH-1:0]                i_CLR_UNDERRUN,
  output logic [NCH*PXW-1:0]            o_PIXEL,
  output logic [NCH-1:0]                o_TRN_n,
  output logic [NCH-1:0]                o_UNDERRUN
);

  localparam int PW = tsa_pw(NPX);

  for (genvar n = 0; n < NCH; n++) begin : g_ch
    tsa_channel #(
      .PXW         (PXW),
      .NPX         (NPX),
      .PW          (PW),
      .LATCH_PHASE (LATCH_PHASE[n*PW +: PW]),
      .ODLY        (int'(ODLY[n*8 +: 8]))
    ) u_channel (
      .clk          (i_EMU_MCLK),
      .rst          (i_EMU_RST),
      .cen_n        (i_EMU_CLK6MPCEN_n),
      .hcnt         (i_HCNT),
      .gfxdata      (i_GFXDATA),
      .mode         (i_MODE[n*2 +: 2]),
      .flip         (i_FLIP[n]),
      .fine         (i_FINE[n*PW +: PW]),
      .clr_underrun (i_CLR_UNDERRUN[n]),
      .pixel        (o_PIXEL[n*PXW +: PXW]),
      .trn_n        (o_TRN_n[n]),
      .underrun     (o_UNDERRUN[n])
    );
  end

endmodule

// File: tb/tb_tilemap_shifter_array.sv
// Directed scoreboard bench for tilemap_shifter_array: stimulus queues expected
// pixel/flag values tagged with the enabled edge they must appear on.
module tb_tilemap_shifter_array;

  localparam logic [1:0] HOLD = 2'b00;
  localparam logic [1:0] SHR  = 2'b01;
  localparam logic [1:0] SHL  = 2'b10;
  localparam logic [1:0] LOAD = 2'b11;

  localparam int K_PIX = 0;
  localparam int K_TRN = 1;
  localparam int K_UND = 2;

  logic        clk;
  logic        rst;
  logic        cen_n;
  logic [2:0]  hcnt;
  logic [31:0] gfx;
  logic [3:0]  mode;
  logic [1:0]  flip;
  logic [5:0]  fine;
  logic [1:0]  clr;
  logic [7:0]  pixel;
  logic [1:0]  trn_n;
  logic [1:0]  underrun;

  int checks = 0;
  int errors = 0;
  int ecnt = 0;
  int next_edge = 0;
  int gap_max = 0;

  int    q_due  [$];
  int    q_kind [$];
  int    q_ch   [$];
  int    q_exp  [$];
  string q_name [$];

  tilemap_shifter_array dut (
    .i_EMU_MCLK        (clk),
    .i_EMU_RST         (rst),
    .i_EMU_CLK6MPCEN_n (cen_n),
    .i_HCNT            (hcnt),
    .i_GFXDATA         (gfx),
    .i_MODE            (mode),
    .i_FLIP            (flip),
    .i_FINE            (fine),
    .i_CLR_UNDERRUN    (clr),
    .o_PIXEL           (pixel),
    .o_TRN_n           (trn_n),
    .o_UNDERRUN        (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!cen_n) ecnt <= ecnt + 1;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (edge %0d)", name, actual, expected, ecnt);
    end
  endtask

  task automatic expectAt(input int due, input int kind, input int ch, input int v, input string name);
    q_due.push_back(due);
    q_kind.push_back(kind);
    q_ch.push_back(ch);
    q_exp.push_back(v);
    q_name.push_back(name);
  endtask

  task automatic expectIdle(input int due);
    for (int c = 0; c < 2; c++) begin
      expectAt(due, K_PIX, c, 0, "reset_pixel");
      expectAt(due, K_TRN, c, 0, "reset_trn");
      expectAt(due, K_UND, c, 0, "reset_underrun");
    end
  endtask

  // One enabled cycle, optionally preceded by random disabled (gap) cycles with junk controls.
  task automatic applyStimulus(input logic rst_v, input logic [1:0] m0, input logic [1:0] m1,
                               input logic [1:0] flip_v, input logic [2:0] f0, input logic [2:0] f1,
                               input logic [2:0] hc, input logic [1:0] clr_v);
    int g;
    g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
    repeat (g) begin
      rst   = 1'b0;
      cen_n = 1'b1;
      mode  = 4'($urandom);
      hcnt  = 3'($urandom);
      clr   = 2'($urandom);
      flip  = 2'($urandom);
      @(posedge clk);
      #1;
    end
    rst   = rst_v;
    cen_n = 1'b0;
    mode  = {m1, m0};
    flip  = flip_v;
    fine  = {f1, f0};
    hcnt  = hc;
    clr   = clr_v;
    next_edge = ecnt + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input logic [1:0] flip_v);
    int b;
    b = 0;
    while (q_due.size() > 0 && b < 64) begin
      applyStimulus(1'b0, HOLD, HOLD, flip_v, fine[2:0], fine[5:3], 3'd0, 2'b00);
      b++;
    end
    if (q_due.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d expectations still pending, required 0", q_due.size());
      q_due.delete(); q_kind.delete(); q_ch.delete(); q_exp.delete(); q_name.delete();
    end
  endtask

  initial begin : monitor
    int last;
    int act;
    last = -1;
    forever begin
      @(negedge clk);
      if (ecnt != last) begin
        last = ecnt;
        for (int i = q_due.size() - 1; i >= 0; i--) begin
          if (q_due[i] <= ecnt) begin
            case (q_kind[i])
              K_PIX:   act = int'(pixel[q_ch[i]*4 +: 4]);
              K_TRN:   act = int'(trn_n[q_ch[i]]);
              default: act = int'(underrun[q_ch[i]]);
            endcase
            checkOutput(q_name[i], act, q_exp[i]);
            q_due.delete(i); q_kind.delete(i); q_ch.delete(i); q_exp.delete(i); q_name.delete(i);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    rst = 1'b1; cen_n = 1'b0; hcnt = 3'd0; gfx = 32'h0; mode = 4'h0;
    flip = 2'b00; fine = 6'd0; clr = 2'b00;
    @(posedge clk);
    #1;

    // Power-up reset
    applyStimulus(1'b1, HOLD, HOLD, 2'b00, 3'd0, 3'd0, 3'd0, 2'b00);
    applyStimulus(1'b1, HOLD, HOLD, 2'b00, 3'd0, 3'd0, 3'd0, 2'b00);
    expectIdle(next_edge);

    // Ch0 left shift, ODLY=3 -> pixel appears 4 edges after the shift edge
    gfx = 32'h12345678;
    applyStimulus(1'b0, HOLD, HOLD, 2'b00, 3'd0, 3'd0, 3'd7, 2'b00);
    applyStimulus(1'b0, LOAD, HOLD, 2'b00, 3'd0, 3'd0, 3'd0, 2'b00);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, SHL, HOLD, 2'b00, 3'd0, 3'd0, 3'd0, 2'b00);
      expectAt(next_edge + 4, K_PIX, 0, k + 1, "ch0_shl");
      if (k == 0) expectAt(next_edge + 4, K_TRN, 0, 1, "ch0_trn_opaque");
    end
    drain(2'b00);

    // Latch and load on the same edge loads the previously latched row
    gfx = 32'h9ABCDEF1;
    applyStimulus(1'b0, LOAD, HOLD, 2'b00, 3'd0, 3'd0, 3'd7, 2'b00);
    applyStimulus(1'b0, SHL, HOLD, 2'b00, 3'd0, 3'd0, 3'd0, 2'b00);
    expectAt(next_edge + 4, K_PIX, 0, 1, "ch0_latch_load_old");
    applyStimulus(1'b0, LOAD, HOLD, 2'b00, 3'd0, 3'd0, 3'd0, 2'b00);
    applyStimulus(1'b0, SHL, HOLD, 2'b00, 3'd0, 3'd0, 3'd0, 2'b00);
    expectAt(next_edge + 4, K_PIX, 0, 9, "ch0_new_row");
    applyStimulus(1'b0, SHL, HOLD, 2'b00, 3'd0, 3'd0, 3'd0, 2'b00);
    expectAt(next_edge + 4, K_PIX, 0, 10, "ch0_new_row");
    drain(2'b00);

    // Ch1 flipped: mismatched SHL gives 0, then SHR yields 8..1 with no pixel lost
    gfx = 32'h12345678;
    applyStimulus(1'b0, HOLD, HOLD, 2'b10, 3'd0, 3'd0, 3'd3, 2'b00);
    applyStimulus(1'b0, HOLD, LOAD, 2'b10, 3'd0, 3'd0, 3'd0, 2'b00);
    applyStimulus(1'b0, HOLD, SHL, 2'b10, 3'd0, 3'd0, 3'd0, 2'b00);
    expectAt(next_edge + 1, K_PIX, 1, 0, "ch1_dir_mismatch");
    expectAt(next_edge + 1, K_TRN, 1, 0, "ch1_trn_clear");
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, HOLD, SHR, 2'b10, 3'd0, 3'd0, 3'd0, 2'b00);
      expectAt(next_edge + 1, K_PIX, 1, 8 - k, "ch1_shr_flip");
    end
    drain(2'b10);

    // Ch1 underrun after 8 shifts, sticky until cleared, set beats clear
    applyStimulus(1'b0, HOLD, LOAD, 2'b00, 3'd0, 3'd0, 3'd0, 2'b00);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, HOLD, SHL, 2'b00, 3'd0, 3'd0, 3'd0, 2'b00);
      expectAt(next_edge + 1, K_PIX, 1, k + 1, "ch1_shl");
    end
    applyStimulus(1'b0, HOLD, SHL, 2'b00, 3'd0, 3'd0, 3'd0, 2'b00);
    expectAt(next_edge + 1, K_PIX, 1, 0, "ch1_underrun_pixel");
    expectAt(next_edge, K_UND, 1, 1, "ch1_underrun_set");
    expectAt(next_edge, K_UND, 0, 0, "ch0_underrun_quiet");
    applyStimulus(1'b0, HOLD, HOLD, 2'b00, 3'd0, 3'd0, 3'd0, 2'b00);
    expectAt(next_edge, K_UND, 1, 1, "ch1_underrun_sticky");
    applyStimulus(1'b0, HOLD, HOLD, 2'b00, 3'd0, 3'd0, 3'd0, 2'b10);
    expectAt(next_edge, K_UND, 1, 0, "ch1_underrun_clear");
    applyStimulus(1'b0, HOLD, SHL, 2'b00, 3'd0, 3'd0, 3'd0, 2'b10);
    expectAt(next_edge, K_UND, 1, 1, "ch1_set_beats_clear");
    applyStimulus(1'b0, HOLD, HOLD, 2'b00, 3'd0, 3'd0, 3'd0, 2'b10);
    expectAt(next_edge, K_UND, 1, 0, "ch1_underrun_clear2");
    drain(2'b00);

    // Fine scroll with random disabled gaps: ch1 FINE=5, then ch0 FINE=2
    gap_max = 2;
    applyStimulus(1'b0, HOLD, LOAD, 2'b00, 3'd0, 3'd5, 3'd0, 2'b00);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, HOLD, SHL, 2'b00, 3'd0, 3'd5, 3'd0, 2'b00);
      expectAt(next_edge + 6, K_PIX, 1, k + 1, "ch1_fine5");
    end
    drain(2'b00);
    applyStimulus(1'b0, LOAD, HOLD, 2'b00, 3'd2, 3'd0, 3'd0, 2'b00);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, SHL, HOLD, 2'b00, 3'd2, 3'd0, 3'd0, 2'b00);
      expectAt(next_edge + 6, K_PIX, 0, 9 + k, "ch0_fine2");
    end
    drain(2'b00);
    gap_max = 0;

    // Reset mid-shift with ch1 underrun set
    applyStimulus(1'b0, LOAD, HOLD, 2'b00, 3'd0, 3'd0, 3'd0, 2'b00);
    applyStimulus(1'b0, SHL, SHL, 2'b00, 3'd0, 3'd0, 3'd0, 2'b00);
    expectAt(next_edge, K_UND, 1, 1, "ch1_underrun_pre_reset");
    applyStimulus(1'b0, SHL, SHL, 2'b00, 3'd0, 3'd0, 3'd0, 2'b00);
    for (int r = 0; r < 3; r++) begin
      applyStimulus(1'b1, SHL, SHL, 2'b00, 3'd0, 3'd0, 3'd7, 2'b00);
      expectIdle(next_edge);
    end
    applyStimulus(1'b0, SHL, HOLD, 2'b00, 3'd0, 3'd0, 3'd0, 2'b00);
    expectAt(next_edge, K_UND, 0, 1, "ch0_rem_zero_after_reset");
    expectAt(next_edge + 4, K_PIX, 0, 0, "ch0_pixel_after_reset");
    applyStimulus(1'b0, HOLD, HOLD, 2'b00, 3'd0, 3'd0, 3'd7, 2'b00);
    applyStimulus(1'b0, LOAD, HOLD, 2'b00, 3'd0, 3'd0, 3'd0, 2'b00);
    applyStimulus(1'b0, SHL, HOLD, 2'b00, 3'd0, 3'd0, 3'd0, 2'b00);
    expectAt(next_edge + 4, K_PIX, 0, 1, "ch0_restart_after_reset");
    drain(2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
